op_button_sync: RTL and testbench
=================================

OP_BUTTON_SYNC -- requirements
Module: op_button_sync

Interface
REQ-001 The block SHALL have parameter DB_LIMIT, default 1000000, giving the number of consecutive cycles a synchronized button level must differ from its debounced level before the debounced level changes (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter DB_W, default 20, giving the debounce counter width; DB_LIMIT SHALL fit in DB_W bits.
REQ-003 Port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port btn  input  4  raw push-buttons: [3] clear, [2] add, [1] sub, [0] mul; asynchronous and bouncing.
REQ-006 Port a_in  input  8  operand A from the switches.
REQ-007 Port b_in  input  8  operand B from the switches.
REQ-008 Port op  output  2  accepted operation: 0 clear, 1 add, 2 sub, 3 mul.
REQ-009 Port op_pulse  output  1  one-cycle strobe, high in the cycle op, a_out and b_out take a new accepted value.
REQ-010 Port rej_pulse  output  1  one-cycle strobe, high when a press is rejected.
REQ-011 Port a_out  output  8  operand A latched at acceptance.
REQ-012 Port b_out  output  8  operand B latched at acceptance.
REQ-013 Port btn_db  output  4  debounced button levels.

Function
REQ-014 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per bit, while the synchronized level differs from btn_db, the counter SHALL increment; when it reaches DB_LIMIT-1, btn_db SHALL take the synchronized level and the counter SHALL clear.
REQ-016 Per bit, any cycle in which the synchronized level equals btn_db SHALL clear the counter, so a glitch shorter than DB_LIMIT cycles never changes btn_db.
REQ-017 A press SHALL be a 0->1 transition of a btn_db bit, detected against a one-cycle-delayed copy of btn_db.
REQ-018 The FSM SHALL have exactly two states: IDLE (reset state) and HELD.
REQ-019 In IDLE, a cycle whose press vector is one-hot and equal to btn_db SHALL cause acceptance and a transition to HELD.
REQ-020 On acceptance, on the next edge the block SHALL set op to the encoding of the pressed button, set a_out to a_in and b_out to b_in as sampled in the accepting cycle, and assert op_pulse for exactly one cycle.
REQ-021 In IDLE, a nonzero press vector that is not one-hot, or that is accompanied by another held btn_db bit, SHALL be rejected: op, a_out and b_out unchanged, rej_pulse high for one cycle, state stays IDLE.
REQ-022 In HELD, any press SHALL be rejected with rej_pulse, and the state SHALL return to IDLE only in a cycle where btn_db equals 0.
REQ-023 Total latency from the first clock edge sampling a clean, held btn level to op_pulse high SHALL be DB_LIMIT+3 cycles.
REQ-024 Outputs op, a_out and b_out SHALL hold their last accepted values indefinitely; op_pulse and rej_pulse SHALL never be high in the same cycle.
REQ-025 A clear press SHALL be accepted like any other button and SHALL set op to 0; it SHALL not reset the debouncers.

Reset
REQ-026 While rst_n is 0, the block SHALL force synchronizers, counters, btn_db, delayed btn_db, op (0), a_out (0), b_out (0), op_pulse (0) and rej_pulse (0) to zero and the FSM to IDLE, regardless of clk.
REQ-027 Deasserting rst_n mid-debounce SHALL restart debouncing from zero; a button held through reset SHALL be accepted DB_LIMIT+3 cycles after deassertion.

Structure
REQ-028 A shared package op_pkg SHALL hold the op encodings (OP_CLR, OP_ADD, OP_SUB, OP_MUL), the button index constants, and the FSM state type.
REQ-029 The synchronizer and counter for one bit SHALL be a sub-module debounce_bit, instantiated four times.

Verification (DB_LIMIT=4)
REQ-030 Hold btn=4'b0100 clean, a_in=8'd12, b_in=8'd5 -> op_pulse high once at cycle 7, op=1, a_out=12, b_out=5.
REQ-031 Pulse btn[1] high for 3 cycles, then low -> btn_db stays 0, no op_pulse, no rej_pulse.
REQ-032 Raise btn[2] and btn[1] on the same cycle, held -> rej_pulse once, op unchanged, FSM stays IDLE.
REQ-033 Accept mul (op=3), then press add while mul is still held -> rej_pulse, op stays 3; release both, press add -> op=1.
REQ-034 Assert rst_n=0 at cycle 5 of a sub press, then release it with sub still held -> all outputs 0 during reset; op=2 with op_pulse 7 cycles after release.
REQ-035 Press clear after an accepted sub -> op=0, op_pulse once, a_out/b_out take the current switch values.

Source files
------------

// File: rtl/op_pkg.sv
// Shared encodings for the operation-button front end: op codes, button
// positions within btn, and the acceptance FSM state type.
package op_pkg;

  localparam logic [1:0] OP_CLR = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  localparam int BTN_CLR = 3;
  localparam int BTN_ADD = 2;
  localparam int BTN_SUB = 1;
  localparam int BTN_MUL = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Only called with a one-hot press vector, so priority order is irrelevant.
  function automatic logic [1:0] op_of_press(input logic [3:0] press);
    logic [1:0] code;
    code = OP_MUL;
    if (press[BTN_CLR])      code = OP_CLR;
    else if (press[BTN_ADD]) code = OP_ADD;
    else if (press[BTN_SUB]) code = OP_SUB;
    return code;
  endfunction

endpackage

// File: rtl/op_button_sync_if.sv
// Operand/result bus of op_button_sync. op_pulse and rej_pulse are
// valid-only strobes (no ready): a consumer must act in the strobe cycle,
// although op/a_out/b_out keep their values until the next acceptance.
interface op_button_sync_if;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [1:0] op;
  logic       op_pulse;
  logic       rej_pulse;
  logic [7:0] a_out;
  logic [7:0] b_out;

  modport master (
    input  a_in, b_in,
    output op, op_pulse, rej_pulse, a_out, b_out
  );

  modport slave (
    output a_in, b_in,
    input  op, op_pulse, rej_pulse, a_out, b_out
  );
endinterface

// File: rtl/op_button_sync_debounce_bit.sv
// One button bit: 2-flop synchronizer followed by a consecutive-cycle
// debounce counter that flips the debounced level after DB_LIMIT cycles.
module debounce_bit #(
  parameter int DB_LIMIT = 1000000,
  parameter int DB_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any agreeing cycle restarts the count, so only a stable change wins.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/op_button_sync.sv
// Debounces four operation buttons and accepts a single clean press,
// latching the op code and the switch operands in the same cycle.
module op_button_sync
  import op_pkg::*;
#(
  parameter int DB_LIMIT = 1000000,
  parameter int DB_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             btn,
  output logic [3:0]             btn_db,
  output state_t                 state_dbg,
  op_button_sync_if.master       bus
);

  logic [3:0] db_d;
  logic [3:0] press;
  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       reject;
  logic [1:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       op_pulse_q;
  logic       rej_pulse_q;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DB_LIMIT (DB_LIMIT),
      .DB_W     (DB_W)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn[i]),
      .level   (btn_db[i])
    );
  end

  assign press = btn_db & ~db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_d  <= '0;
      state <= ST_IDLE;
    end else begin
      db_d  <= btn_db;
      state <= state_nxt;
    end
  end

  // A press is accepted only when it is the sole button held down.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press != 4'b0000) begin
          if ($onehot(press) && (press == btn_db)) begin
            accept    = 1'b1;
            state_nxt = ST_HELD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (press != 4'b0000) reject = 1'b1;
        if (btn_db == 4'b0000) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_CLR;
      a_q         <= '0;
      b_q         <= '0;
      op_pulse_q  <= 1'b0;
      rej_pulse_q <= 1'b0;
    end else begin
      op_pulse_q  <= accept;
      rej_pulse_q <= reject;
      if (accept) begin
        op_q <= op_of_press(press);
        a_q  <= bus.a_in;
        b_q  <= bus.b_in;
      end
    end
  end

  assign bus.op        = op_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_pulse  = op_pulse_q;
  assign bus.rej_pulse = rej_pulse_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_op_button_sync.sv
// Directed bench for op_button_sync with DB_LIMIT=4: clean press latency,
// glitch rejection, multi-press rejection, held-press rejection, reset.
module tb_op_button_sync;
  import op_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] btn_db;
  state_t     state_dbg;
  int         total;
  int         bad;
  int         n_op;
  int         n_rej;
  int         n_both;

  op_button_sync_if bus ();

  op_button_sync #(
    .DB_LIMIT (4),
    .DB_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .btn_db    (btn_db),
    .state_dbg (state_dbg),
    .bus       (bus.master)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    n_op   = 0;
    n_rej  = 0;
    n_both = 0;
    repeat (n) begin
      tick();
      if (bus.op_pulse) n_op++;
      if (bus.rej_pulse) n_rej++;
      if (bus.op_pulse && bus.rej_pulse) n_both++;
    end
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op"}, 32'(bus.op), 32'd0);
    chk({tag, "_a"}, 32'(bus.a_out), 32'd0);
    chk({tag, "_b"}, 32'(bus.b_out), 32'd0);
    chk({tag, "_opp"}, 32'(bus.op_pulse), 32'd0);
    chk({tag, "_rej"}, 32'(bus.rej_pulse), 32'd0);
    chk({tag, "_db"}, 32'(btn_db), 32'd0);
    chk({tag, "_st"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b1;
    btn      = 4'b0000;
    bus.a_in = 8'd0;
    bus.b_in = 8'd0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    run(2);

    // clean add press: pulse exactly on the 7th edge
    bus.a_in = 8'd12;
    bus.b_in = 8'd5;
    btn      = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t1_pulse", 32'(bus.op_pulse), 32'(c == 7));
      chk("t1_rej", 32'(bus.rej_pulse), 32'd0);
      if (c == 7) begin
        chk("t1_op", 32'(bus.op), 32'(OP_ADD));
        chk("t1_a", 32'(bus.a_out), 32'd12);
        chk("t1_b", 32'(bus.b_out), 32'd5);
      end
    end
    chk("t1_held", 32'(state_dbg), 32'(ST_HELD));
    bus.a_in = 8'd99;
    btn      = 4'b0000;
    run(10);
    chk("t1_a_hold", 32'(bus.a_out), 32'd12);
    chk("t1_rel_op", 32'(n_op), 32'd0);
    chk("t1_rel_st", 32'(state_dbg), 32'(ST_IDLE));

    // 3-cycle glitch on sub never reaches btn_db
    btn = 4'b0010;
    run(3);
    btn = 4'b0000;
    run(12);
    chk("t2_db", 32'(btn_db), 32'd0);
    chk("t2_op", 32'(n_op), 32'd0);
    chk("t2_rej", 32'(n_rej), 32'd0);

    // add+sub together -> rejected once
    btn = 4'b0110;
    run(10);
    chk("t3_rej", 32'(n_rej), 32'd1);
    chk("t3_opp", 32'(n_op), 32'd0);
    chk("t3_op", 32'(bus.op), 32'(OP_ADD));
    chk("t3_st", 32'(state_dbg), 32'(ST_IDLE));
    btn = 4'b0000;
    run(10);

    // mul accepted, add while mul held rejected, then add alone accepted
    bus.a_in = 8'd7;
    bus.b_in = 8'd3;
    btn      = 4'b0001;
    run(10);
    chk("t4_mul_opp", 32'(n_op), 32'd1);
    chk("t4_mul_op", 32'(bus.op), 32'(OP_MUL));
    chk("t4_mul_a", 32'(bus.a_out), 32'd7);
    chk("t4_mul_b", 32'(bus.b_out), 32'd3);
    btn = 4'b0101;
    run(10);
    chk("t4_hold_rej", 32'(n_rej), 32'd1);
    chk("t4_hold_opp", 32'(n_op), 32'd0);
    chk("t4_hold_op", 32'(bus.op), 32'(OP_MUL));
    chk("t4_both", 32'(n_both), 32'd0);
    btn = 4'b0000;
    run(10);
    chk("t4_rel_st", 32'(state_dbg), 32'(ST_IDLE));
    bus.a_in = 8'd20;
    bus.b_in = 8'd21;
    btn      = 4'b0100;
    run(10);
    chk("t4_add_opp", 32'(n_op), 32'd1);
    chk("t4_add_op", 32'(bus.op), 32'(OP_ADD));
    chk("t4_add_a", 32'(bus.a_out), 32'd20);
    chk("t4_add_b", 32'(bus.b_out), 32'd21);
    btn = 4'b0000;
    run(10);

    // reset mid sub debounce, sub held through reset
    bus.a_in = 8'd33;
    bus.b_in = 8'd44;
    btn      = 4'b0010;
    run(5);
    chk("t5_pre_opp", 32'(n_op), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    repeat (2) tick();
    chk_all_zero("t5_rst");
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t5_pulse", 32'(bus.op_pulse), 32'(c == 7));
      if (c == 7) begin
        chk("t5_op", 32'(bus.op), 32'(OP_SUB));
        chk("t5_a", 32'(bus.a_out), 32'd33);
      end
    end
    btn = 4'b0000;
    run(10);

    // clear after sub: op=0, operands refreshed, debouncer keeps level
    bus.a_in = 8'd100;
    bus.b_in = 8'd200;
    btn      = 4'b1000;
    run(10);
    chk("t6_opp", 32'(n_op), 32'd1);
    chk("t6_op", 32'(bus.op), 32'(OP_CLR));
    chk("t6_a", 32'(bus.a_out), 32'd100);
    chk("t6_b", 32'(bus.b_out), 32'd200);
    chk("t6_db", 32'(btn_db), 32'b1000);
    btn = 4'b0000;
    run(10);
    chk("t6_end_st", 32'(state_dbg), 32'(ST_IDLE));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
